// File: rtl/rx_packet_framer_if.sv
// Transceiver RX word stream in, framed payload stream and link statistics out.
// The framer takes the slave view; the driving environment takes the master view.
interface rx_packet_framer_if;
    logic [1:0]  rx_syncstatus;
    logic [1:0]  rx_datak;
    logic [15:0] rx_data;
    logic        link_up;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic        out_err;
    logic [6:0]  pkt_len;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    modport master (
        output rx_syncstatus, rx_datak, rx_data,
        input  link_up, out_data, out_valid, out_sop, out_eop, out_err,
        input  pkt_len, pkt_count, err_count
    );

    modport slave (
        input  rx_syncstatus, rx_datak, rx_data,
        output link_up, out_data, out_valid, out_sop, out_eop, out_err,
        output pkt_len, pkt_count, err_count
    );
endinterface

// File: rtl/rx_packet_framer.sv
// RX framing stage: qualifies link sync, strips K-idles, finds start/cont/end markers,
// enforces payload length limits and keeps link statistics. Single clock rx_std_clkout.
module rx_packet_framer #(
    parameter logic [15:0] START_WORD  = 16'hDEAD,
    parameter logic [15:0] CONT_WORD   = 16'hBEEF,
    parameter logic [15:0] END_WORD    = 16'h7FFF,
    parameter int unsigned MIN_LEN     = 121,
    parameter int unsigned MAX_LEN     = 126,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input logic            rx_std_clkout,
    input logic            rst_n,
    rx_packet_framer_if.slave bus
);

    localparam int unsigned      LockW   = $clog2(LOCK_CYCLES + 1);
    localparam logic [LockW-1:0] LockMax = LockW'(LOCK_CYCLES);
    localparam logic [6:0]       MinLen  = 7'(MIN_LEN);
    localparam logic [6:0]       MaxLen  = 7'(MAX_LEN);

    if (MIN_LEN < 1 || MAX_LEN < MIN_LEN || MAX_LEN > 127) begin : g_bad_params
        $error("rx_packet_framer: need 1 <= MIN_LEN <= MAX_LEN <= 127");
    end

    typedef enum logic [1:0] {StIdle, StHunt, StPayload, StGap} state_e;

    state_e           state_q;
    logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
    logic [6:0]       len_q;
    logic             link_up_d;
    logic             sync_ok;
    logic             qw;
    logic             sync_lost;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        sync_ok   = (bus.rx_syncstatus == 2'b11);
        qw        = bus.link_up && sync_ok && (bus.rx_datak == 2'b00);
        sync_lost = bus.link_up && !sync_ok;
        if (!sync_ok) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q == LockMax) begin
            lock_cnt_d = lock_cnt_q;
        end else begin
            lock_cnt_d = lock_cnt_q + LockW'(1);
        end
        link_up_d = (lock_cnt_d == LockMax);
    end

    always_ff @(posedge rx_std_clkout) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            lock_cnt_q    <= '0;
            len_q         <= '0;
            bus.link_up   <= 1'b0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            bus.out_err   <= 1'b0;
            bus.pkt_len   <= '0;
            bus.pkt_count <= '0;
            bus.err_count <= '0;
        end else begin
            lock_cnt_q    <= lock_cnt_d;
            bus.link_up   <= link_up_d;
            bus.out_valid <= 1'b0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            bus.out_err   <= 1'b0;
            if (sync_lost) begin
                // Only an open packet gets an errored eop; elsewhere the loss is just counted.
                state_q       <= StIdle;
                len_q         <= '0;
                bus.err_count <= sat_inc(bus.err_count);
                if (state_q == StPayload) begin
                    bus.out_eop <= 1'b1;
                    bus.out_err <= 1'b1;
                    bus.pkt_len <= len_q;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        if (link_up_d) state_q <= StHunt;
                    end
                    StHunt: begin
                        if (qw && bus.rx_data == START_WORD) begin
                            state_q <= StPayload;
                            len_q   <= '0;
                        end
                    end
                    StPayload: begin
                        if (qw) begin
                            if (bus.rx_data == END_WORD && len_q >= MinLen) begin
                                state_q       <= StGap;
                                bus.out_eop   <= 1'b1;
                                bus.pkt_len   <= len_q;
                                bus.pkt_count <= sat_inc(bus.pkt_count);
                            end else if (len_q == MaxLen) begin
                                state_q       <= StHunt;
                                bus.out_eop   <= 1'b1;
                                bus.out_err   <= 1'b1;
                                bus.pkt_len   <= MaxLen;
                                bus.err_count <= sat_inc(bus.err_count);
                            end else begin
                                bus.out_valid <= 1'b1;
                                bus.out_data  <= bus.rx_data;
                                bus.out_sop   <= (len_q == 7'd0);
                                len_q         <= len_q + 7'd1;
                            end
                        end
                    end
                    StGap: begin
                        if (qw) begin
                            len_q <= '0;
                            if (bus.rx_data == CONT_WORD || bus.rx_data == START_WORD) begin
                                state_q <= StPayload;
                            end else begin
                                state_q <= StHunt;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_packet_framer.sv
// Self-checking bench for rx_packet_framer: scoreboard of expected output events,
// each stamped with the cycle it must appear in (one cycle after the causing input).
module tb_rx_packet_framer;

    typedef struct {
        int         at_cyc;
        bit         is_word;
        logic [15:0] data;
        logic       sop;
        logic       err;
        logic [6:0] len;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    rx_packet_framer_if bus ();

    rx_packet_framer dut (
        .rx_std_clkout(clk),
        .rst_n        (rst_n),
        .bus          (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    // Output monitor: every valid/eop event must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        checks = checks + 1;
        if (bus.out_valid && bus.out_eop) begin
            errors = errors + 1;
            $display("FAIL valid_eop_overlap cyc=%0d both high, required never together", cyc);
        end
        while (exp_q.size() > 0 && exp_q[0].at_cyc < cyc) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL missing_output got none, required word=%0b data=%h at cyc %0d",
                     e.is_word, e.data, e.at_cyc);
        end
        if (bus.out_valid || bus.out_eop) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_output cyc=%0d valid=%0b eop=%0b data=%h, required none",
                         cyc, bus.out_valid, bus.out_eop, bus.out_data);
            end else begin
                e = exp_q.pop_front();
                if (cyc !== e.at_cyc || bus.out_valid !== e.is_word ||
                    (e.is_word && (bus.out_data !== e.data || bus.out_sop !== e.sop)) ||
                    (!e.is_word && (bus.out_err !== e.err || bus.pkt_len !== e.len))) begin
                    errors = errors + 1;
                    $display({"FAIL output_event got cyc=%0d valid=%0b data=%h sop=%0b err=%0b ",
                              "len=%0d, required cyc=%0d valid=%0b data=%h sop=%0b err=%0b len=%0d"},
                             cyc, bus.out_valid, bus.out_data, bus.out_sop, bus.out_err,
                             bus.pkt_len, e.at_cyc, e.is_word, e.data, e.sop, e.err, e.len);
                end
            end
        end
    end

    task automatic step(input logic [1:0] s, input logic [1:0] k, input logic [15:0] d);
        bus.rx_syncstatus = s;
        bus.rx_datak      = k;
        bus.rx_data       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] d);
        step(2'b11, 2'b00, d);
    endtask

    task automatic send_idle();
        step(2'b11, 2'b01, 16'hBCBC);
    endtask

    task automatic exp_word(input logic [15:0] d, input logic sop);
        exp_q.push_back('{at_cyc: cyc + 1, is_word: 1'b1, data: d, sop: sop, err: 1'b0, len: 7'd0});
    endtask

    task automatic exp_eop(input logic err, input logic [6:0] len);
        exp_q.push_back('{at_cyc: cyc + 1, is_word: 1'b0, data: 16'h0, sop: 1'b0, err: err, len: len});
    endtask

    // n payload words base+i, with K-idles at indices 30 and 90; index end_at carries 7FFF.
    task automatic send_payload(input int n, input logic [15:0] base, input int end_at);
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
            d = (i == end_at) ? 16'h7FFF : base + 16'(i);
            if (i == 30 || i == 90) send_idle();
            exp_word(d, i == 0);
            send_word(d);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
        checks = checks + 1;
        if (got !== req) begin
            errors = errors + 1;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 16'h0);
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic lock_link();
        for (int i = 0; i < 16; i++) send_idle();
    endtask

    task automatic drain_check(input string name);
        for (int i = 0; i < 3; i++) send_idle();
        check_val({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step(2'b11, 2'b00, 16'hDEAD);
        check_val("reset_flags", {bus.link_up, bus.out_valid, bus.out_sop, bus.out_eop, bus.out_err},
                  32'd0);
        check_val("reset_data_len", {bus.out_data, bus.pkt_len}, 32'd0);
        check_val("reset_counters", {bus.pkt_count, bus.err_count}, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i < 15; i++) send_idle();
        check_val("lock_15_cycles", 32'(bus.link_up), 32'd0);
        send_idle();
        check_val("lock_16_cycles", 32'(bus.link_up), 32'd1);
        step(2'b01, 2'b00, 16'h0);
        check_val("glitch_link_down", 32'(bus.link_up), 32'd0);
        check_val("glitch_err_count", 32'(bus.err_count), 32'd1);
        for (int i = 0; i < 15; i++) send_idle();
        check_val("relock_15_cycles", 32'(bus.link_up), 32'd0);
        send_idle();
        check_val("relock_16_cycles", 32'(bus.link_up), 32'd1);
        drain_check("lock");
    endtask

    task automatic test_good_packet();
        do_reset();
        lock_link();
        send_word(16'hDEAD);
        send_payload(121, 16'h0000, -1);
        exp_eop(1'b0, 7'd121);
        send_word(16'h7FFF);
        check_val("good_pkt_count", 32'(bus.pkt_count), 32'd1);
        check_val("good_err_count", 32'(bus.err_count), 32'd0);
        drain_check("good");
    endtask

    task automatic test_early_end();
        do_reset();
        lock_link();
        send_word(16'hDEAD);
        send_payload(122, 16'h0200, 50);
        exp_eop(1'b0, 7'd122);
        send_word(16'h7FFF);
        check_val("early_end_pkt_len", 32'(bus.pkt_len), 32'd122);
        drain_check("early_end");
    endtask

    task automatic test_back_to_back();
        do_reset();
        lock_link();
        send_word(16'hDEAD);
        send_payload(121, 16'h1000, -1);
        exp_eop(1'b0, 7'd121);
        send_word(16'h7FFF);
        send_word(16'hBEEF);
        send_payload(121, 16'h2000, -1);
        exp_eop(1'b0, 7'd121);
        send_word(16'h7FFF);
        check_val("b2b_pkt_count", 32'(bus.pkt_count), 32'd2);
        // A non-marker after the end drops back to hunting; payload is ignored until DEAD.
        send_word(16'h1234);
        for (int i = 0; i < 8; i++) send_word(16'h3000 + 16'(i));
        send_word(16'hBEEF);
        send_word(16'h7FFF);
        send_word(16'hDEAD);
        send_payload(121, 16'h4000, -1);
        exp_eop(1'b0, 7'd121);
        send_word(16'h7FFF);
        check_val("b2b_hunt_pkt_count", 32'(bus.pkt_count), 32'd3);
        drain_check("b2b");
    endtask

    task automatic test_overrun();
        do_reset();
        lock_link();
        send_word(16'hDEAD);
        send_payload(126, 16'h0100, -1);
        exp_eop(1'b1, 7'd126);
        send_word(16'h5555);
        check_val("overrun_err_count", 32'(bus.err_count), 32'd1);
        check_val("overrun_pkt_count", 32'(bus.pkt_count), 32'd0);
        // Back in HUNT: ordinary words are discarded, DEAD opens a new packet.
        send_word(16'h6666);
        send_word(16'hDEAD);
        exp_word(16'h0042, 1'b1);
        send_word(16'h0042);
        drain_check("overrun");
    endtask

    task automatic test_sync_loss();
        do_reset();
        lock_link();
        send_word(16'hDEAD);
        send_payload(60, 16'h0500, -1);
        exp_eop(1'b1, 7'd60);
        step(2'b01, 2'b00, 16'h0600);
        check_val("sync_loss_link_up", 32'(bus.link_up), 32'd0);
        check_val("sync_loss_err_count", 32'(bus.err_count), 32'd1);
        for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 16'h0);
        check_val("sync_loss_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        lock_link();
        send_word(16'hDEAD);
        send_payload(10, 16'h0700, -1);
        rst_n = 1'b0;
        send_word(16'h7FFF);
        check_val("mid_reset_flags",
                  {bus.link_up, bus.out_valid, bus.out_sop, bus.out_eop, bus.out_err}, 32'd0);
        check_val("mid_reset_data_len", {bus.out_data, bus.pkt_len}, 32'd0);
        check_val("mid_reset_counters", {bus.pkt_count, bus.err_count}, 32'd0);
        rst_n = 1'b1;
        drain_check("mid_reset");
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        cyc               = 0;
        rst_n             = 1'b0;
        bus.rx_syncstatus = 2'b00;
        bus.rx_datak      = 2'b00;
        bus.rx_data       = 16'h0;
        test_reset();
        test_lock();
        test_good_packet();
        test_early_end();
        test_back_to_back();
        test_overrun();
        test_sync_loss();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
